// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver: extends an upstream 0-9 ones counter
// with tens/hundreds/thousands and scans the digits with optional leading-zero blanking.
module seg7_scan_driver #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic [3:0] bcd_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       rollover
);

  localparam int              CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_OFF  = 7'b1111111;
  localparam logic [3:0]      AN_OFF   = 4'b1111;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  logic [3:0]       prev_ones_p0;
  logic [3:0]       tens_p0;
  logic [3:0]       hundreds_p0;
  logic [3:0]       thousands_p0;
  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       scan_idx;
  logic [6:0]       seg_p1;
  logic [3:0]       an_p1;
  logic             rollover_p1;

  logic             carry;
  logic             upper_max;
  logic [3:0]       sel_digit;
  logic [3:0]       sel_an;
  logic             sel_blank;

  assign carry     = (prev_ones_p0 == 4'd9) && (bcd_in == 4'd0);
  assign upper_max = (tens_p0 == 4'd9) && (hundreds_p0 == 4'd9) && (thousands_p0 == 4'd9);

  // Stage p0: ones sampling, BCD carry chain and refresh/scan counters
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      prev_ones_p0 <= 4'd0;
      tens_p0      <= 4'd0;
      hundreds_p0  <= 4'd0;
      thousands_p0 <= 4'd0;
      refresh_cnt  <= '0;
      scan_idx     <= 2'd0;
    end else begin
      prev_ones_p0 <= bcd_in;
      if (carry) begin
        if (tens_p0 == 4'd9) begin
          tens_p0 <= 4'd0;
          if (hundreds_p0 == 4'd9) begin
            hundreds_p0  <= 4'd0;
            thousands_p0 <= (thousands_p0 == 4'd9) ? 4'd0 : thousands_p0 + 4'd1;
          end else begin
            hundreds_p0 <= hundreds_p0 + 4'd1;
          end
        end else begin
          tens_p0 <= tens_p0 + 4'd1;
        end
      end
      if (refresh_cnt == CNT_LAST) begin
        refresh_cnt <= '0;
        scan_idx    <= scan_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero
  always_comb begin
    sel_digit = prev_ones_p0;
    sel_an    = 4'b1110;
    sel_blank = 1'b0;
    case (scan_idx)
      2'd1: begin
        sel_digit = tens_p0;
        sel_an    = 4'b1101;
        sel_blank = BLANK_LEADING && (tens_p0 == 4'd0) && (hundreds_p0 == 4'd0)
                    && (thousands_p0 == 4'd0);
      end
      2'd2: begin
        sel_digit = hundreds_p0;
        sel_an    = 4'b1011;
        sel_blank = BLANK_LEADING && (hundreds_p0 == 4'd0) && (thousands_p0 == 4'd0);
      end
      2'd3: begin
        sel_digit = thousands_p0;
        sel_an    = 4'b0111;
        sel_blank = BLANK_LEADING && (thousands_p0 == 4'd0);
      end
      default: ;
    endcase
  end

  // Stage p1: registered display outputs and wrap pulse
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      seg_p1      <= SEG_OFF;
      an_p1       <= AN_OFF;
      rollover_p1 <= 1'b0;
    end else begin
      seg_p1      <= sel_blank ? SEG_OFF : seg_encode(sel_digit);
      an_p1       <= sel_blank ? AN_OFF : sel_an;
      rollover_p1 <= carry && upper_max;
    end
  end

  assign seg      = seg_p1;
  assign an       = an_p1;
  assign rollover = rollover_p1;
  assign dp       = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: one blanking instance and one full-display
// instance share clock, reset and ones input.
module tb_seg7_scan_driver;

  logic       clock_100Mhz = 1'b0;
  logic       reset        = 1'b1;
  logic [3:0] bcd_in       = 4'd0;
  logic [6:0] a_seg, b_seg;
  logic [3:0] a_an, b_an;
  logic       a_dp, b_dp, a_rollover, b_rollover;

  int tests = 0;
  int fails = 0;
  int ncyc;

  localparam logic [6:0] SOFF = 7'b1111111;
  localparam logic [3:0] AOFF = 4'b1111;

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut_a (
    .clock_100Mhz(clock_100Mhz), .reset(reset), .bcd_in(bcd_in),
    .seg(a_seg), .dp(a_dp), .an(a_an), .rollover(a_rollover));

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_b (
    .clock_100Mhz(clock_100Mhz), .reset(reset), .bcd_in(bcd_in),
    .seg(b_seg), .dp(b_dp), .an(b_an), .rollover(b_rollover));

  always #5 clock_100Mhz = ~clock_100Mhz;

  // edges since reset release; after edge n the display shows slot ((n-1)/4)%4
  always @(posedge clock_100Mhz or negedge reset)
    if (!reset) ncyc <= 0;
    else        ncyc <= ncyc + 1;

  function automatic int slot_of(input int n);
    return ((n - 1) / 4) % 4;
  endfunction

  task automatic apply_reset(input logic [3:0] v);
    @(negedge clock_100Mhz);
    reset  = 1'b0;
    bcd_in = v;
    repeat (2) @(negedge clock_100Mhz);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clock_100Mhz);
    #2 reset = 1'b0;
    #1;
    tests++; if (a_seg !== SOFF) begin fails++; $display("FAIL reset_a_seg got %b want %b", a_seg, SOFF); end
    tests++; if (a_an !== AOFF) begin fails++; $display("FAIL reset_a_an got %b want %b", a_an, AOFF); end
    tests++; if (a_dp !== 1'b1) begin fails++; $display("FAIL reset_a_dp got %b want 1", a_dp); end
    tests++; if (a_rollover !== 1'b0) begin fails++; $display("FAIL reset_a_roll got %b want 0", a_rollover); end
    tests++; if (b_seg !== SOFF) begin fails++; $display("FAIL reset_b_seg got %b want %b", b_seg, SOFF); end
    tests++; if (b_an !== AOFF) begin fails++; $display("FAIL reset_b_an got %b want %b", b_an, AOFF); end
    repeat (3) @(negedge clock_100Mhz);
    tests++; if (a_an !== AOFF || a_seg !== SOFF) begin fails++; $display("FAIL reset_hold got an=%b seg=%b want 1111/1111111", a_an, a_seg); end
  endtask

  task automatic test_single_digit;
    logic [3:0] ea; logic [6:0] es; int s;
    apply_reset(4'd5);
    for (int n = 1; n <= 24; n++) begin
      @(negedge clock_100Mhz);
      s  = slot_of(n);
      ea = (s == 0) ? 4'b1110 : AOFF;
      es = (s == 0) ? ((n == 1) ? 7'b1000000 : 7'b0010010) : SOFF;
      tests++; if (a_an !== ea) begin fails++; $display("FAIL single_an n=%0d got %b want %b", n, a_an, ea); end
      tests++; if (a_seg !== es) begin fails++; $display("FAIL single_seg n=%0d got %b want %b", n, a_seg, es); end
      tests++; if (a_dp !== 1'b1) begin fails++; $display("FAIL single_dp n=%0d got %b want 1", n, a_dp); end
    end
  endtask

  task automatic test_tens;
    logic [3:0] ea; logic [6:0] es; int s;
    apply_reset(4'd0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock_100Mhz);
      bcd_in = 4'(k % 10);
    end
    repeat (2) @(negedge clock_100Mhz);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock_100Mhz);
      s = slot_of(ncyc);
      case (s)
        0:       begin ea = 4'b1110; es = 7'b1000000; end
        1:       begin ea = 4'b1101; es = 7'b0100100; end
        default: begin ea = AOFF;    es = SOFF;       end
      endcase
      tests++; if (a_an !== ea) begin fails++; $display("FAIL tens_an slot=%0d got %b want %b", s, a_an, ea); end
      tests++; if (a_seg !== es) begin fails++; $display("FAIL tens_seg slot=%0d got %b want %b", s, a_seg, es); end
    end
    tests++; if (a_rollover !== 1'b0) begin fails++; $display("FAIL tens_roll got %b want 0", a_rollover); end
  endtask

  task automatic test_rollover;
    int bad; logic [3:0] ea; logic [6:0] es; int s;
    bad = 0;
    apply_reset(4'd0);
    for (int rep = 0; rep < 999; rep++) begin
      for (int k = 1; k <= 10; k++) begin
        @(negedge clock_100Mhz);
        if (a_rollover !== 1'b0) bad++;
        bcd_in = 4'(k % 10);
      end
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock_100Mhz);
      if (a_rollover !== 1'b0) bad++;
      bcd_in = 4'(k);
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL preload_roll got %0d pulses want 0", bad); end
    @(negedge clock_100Mhz);
    bcd_in = 4'd0;
    tests++; if (a_rollover !== 1'b0) begin fails++; $display("FAIL roll_before got %b want 0", a_rollover); end
    @(negedge clock_100Mhz);
    tests++; if (a_rollover !== 1'b1) begin fails++; $display("FAIL roll_pulse got %b want 1", a_rollover); end
    @(negedge clock_100Mhz);
    tests++; if (a_rollover !== 1'b0) begin fails++; $display("FAIL roll_after got %b want 0", a_rollover); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clock_100Mhz);
      s  = slot_of(ncyc);
      ea = (s == 0) ? 4'b1110 : AOFF;
      es = (s == 0) ? 7'b1000000 : SOFF;
      tests++; if (a_an !== ea) begin fails++; $display("FAIL roll_an slot=%0d got %b want %b", s, a_an, ea); end
      tests++; if (a_seg !== es) begin fails++; $display("FAIL roll_seg slot=%0d got %b want %b", s, a_seg, es); end
    end
  endtask

  task automatic test_invalid_ones;
    logic [3:0] ea; logic [6:0] es; int s;
    apply_reset(4'd0);
    @(negedge clock_100Mhz); bcd_in = 4'd9;
    @(negedge clock_100Mhz); bcd_in = 4'd12;
    repeat (2) @(negedge clock_100Mhz);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock_100Mhz);
      s  = slot_of(ncyc);
      ea = (s == 0) ? 4'b1110 : AOFF;
      tests++; if (a_an !== ea) begin fails++; $display("FAIL inv12_an slot=%0d got %b want %b", s, a_an, ea); end
      tests++; if (a_seg !== SOFF) begin fails++; $display("FAIL inv12_seg slot=%0d got %b want %b", s, a_seg, SOFF); end
    end
    bcd_in = 4'd0;
    repeat (2) @(negedge clock_100Mhz);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock_100Mhz);
      s  = slot_of(ncyc);
      ea = (s == 0) ? 4'b1110 : AOFF;
      es = (s == 0) ? 7'b1000000 : SOFF;
      tests++; if (a_an !== ea) begin fails++; $display("FAIL inv0_an slot=%0d got %b want %b", s, a_an, ea); end
      tests++; if (a_seg !== es) begin fails++; $display("FAIL inv0_seg slot=%0d got %b want %b", s, a_seg, es); end
      tests++; if (a_rollover !== 1'b0) begin fails++; $display("FAIL inv_roll got %b want 0", a_rollover); end
    end
  endtask

  task automatic test_no_blank;
    logic [3:0] eb, ea; logic [6:0] esb, esa; int s;
    apply_reset(4'd7);
    repeat (2) @(negedge clock_100Mhz);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock_100Mhz);
      s = slot_of(ncyc);
      case (s)
        0:       begin eb = 4'b1110; esb = 7'b1111000; end
        1:       begin eb = 4'b1101; esb = 7'b1000000; end
        2:       begin eb = 4'b1011; esb = 7'b1000000; end
        default: begin eb = 4'b0111; esb = 7'b1000000; end
      endcase
      ea  = (s == 0) ? 4'b1110 : AOFF;
      esa = (s == 0) ? 7'b1111000 : SOFF;
      tests++; if (b_an !== eb) begin fails++; $display("FAIL noblank_an slot=%0d got %b want %b", s, b_an, eb); end
      tests++; if (b_seg !== esb) begin fails++; $display("FAIL noblank_seg slot=%0d got %b want %b", s, b_seg, esb); end
      tests++; if (a_an !== ea) begin fails++; $display("FAIL blank7_an slot=%0d got %b want %b", s, a_an, ea); end
      tests++; if (a_seg !== esa) begin fails++; $display("FAIL blank7_seg slot=%0d got %b want %b", s, a_seg, esa); end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] ea; logic [6:0] es; int s; bit found;
    found = 1'b0;
    apply_reset(4'd0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock_100Mhz);
      bcd_in = 4'(k % 10);
    end
    @(negedge clock_100Mhz); bcd_in = 4'd4;
    repeat (2) @(negedge clock_100Mhz);
    for (int i = 0; i < 32 && !found; i++) begin
      @(negedge clock_100Mhz);
      if (slot_of(ncyc) == 1 && ((ncyc - 1) % 4) == 1) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL mid_find got no slot1 window want one within 32 cycles");
    end else begin
      tests++; if (a_an !== 4'b1101 || a_seg !== 7'b0110000) begin fails++; $display("FAIL mid_tens3 got an=%b seg=%b want 1101/0110000", a_an, a_seg); end
    end
    @(posedge clock_100Mhz);
    #3 reset = 1'b0;
    #1;
    tests++; if (a_seg !== SOFF) begin fails++; $display("FAIL mid_async_seg got %b want %b", a_seg, SOFF); end
    tests++; if (a_an !== AOFF) begin fails++; $display("FAIL mid_async_an got %b want %b", a_an, AOFF); end
    tests++; if (b_an !== AOFF || b_seg !== SOFF) begin fails++; $display("FAIL mid_async_b got an=%b seg=%b want 1111/1111111", b_an, b_seg); end
    tests++; if (a_rollover !== 1'b0) begin fails++; $display("FAIL mid_async_roll got %b want 0", a_rollover); end
    @(negedge clock_100Mhz); bcd_in = 4'd0;
    @(negedge clock_100Mhz); reset = 1'b1;
    repeat (2) @(negedge clock_100Mhz);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock_100Mhz);
      s  = slot_of(ncyc);
      ea = (s == 0) ? 4'b1110 : AOFF;
      es = (s == 0) ? 7'b1000000 : SOFF;
      tests++; if (a_an !== ea) begin fails++; $display("FAIL restart_an slot=%0d got %b want %b", s, a_an, ea); end
      tests++; if (a_seg !== es) begin fails++; $display("FAIL restart_seg slot=%0d got %b want %b", s, a_seg, es); end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_digit();
    test_tens();
    test_rollover();
    test_invalid_ones();
    test_no_blank();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
